// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, data width and the multiplier controller states.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational ALU; carry/flags are left to the consumer.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]        sel_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (sel_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_PASS: y_o = a_i;
            ALU_SHL:  y_o = a_i << 1;
            ALU_SHR:  y_o = a_i >> 1;
            ALU_ZERO: y_o = '0;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_ctrl.sv
// 8x8 unsigned shift-add multiplier sequencing the shared ALU: 8 ADD/SHIFT
// iterations, then a one-cycle DONE that latches the 16-bit product.
module alu_mul_ctrl
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     mcand,
    input  logic [DATA_W-1:0]     mplier,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product,
    output logic                  prod_zero
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mc_q, mc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                c_q, c_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] product_q, product_d;
    logic                prod_zero_q, prod_zero_d;

    logic [2:0]          alu_sel;
    logic [DATA_W-1:0]   alu_a, alu_b, alu_y;

    alu u_alu (
        .sel_i (alu_sel),
        .a_i   (alu_a),
        .b_i   (alu_b),
        .y_o   (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        mc_d        = mc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        prod_zero_d = prod_zero_q;
        alu_sel     = ALU_PASS;
        alu_a       = '0;
        alu_b       = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mc_d    = mcand;
                    lo_d    = mplier;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy    = 1'b1;
                alu_sel = ALU_ADD;
                alu_a   = hi_q;
                alu_b   = mc_q;
                if (lo_q[0]) begin
                    hi_d = alu_y;
                    // Wrapped sum is smaller than an operand exactly when it overflowed.
                    c_d  = (alu_y < hi_q);
                end else begin
                    c_d  = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                alu_sel = ALU_SHR;
                alu_a   = hi_q;
                hi_d    = {c_q, alu_y[DATA_W-2:0]};
                lo_d    = {hi_q[0], lo_q[DATA_W-1:1]};
                c_d     = 1'b0;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? DONE : ADD;
            end
            DONE: begin
                done        = 1'b1;
                product_d   = {hi_q, lo_q};
                prod_zero_d = ({hi_q, lo_q} == '0);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mc_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            prod_zero_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mc_q        <= mc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            prod_zero_q <= prod_zero_d;
        end
    end

    assign product   = product_q;
    assign prod_zero = prod_zero_q;

endmodule
